// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit owning the HI/LO registers
//
// Executes MULT/MULTU (radix-2 shift-add) and DIV/DIVU (radix-2 restoring)
// one bit per cycle, and stalls the pipeline while it works. MTHI/MTLO write
// HI/LO directly from IDLE without stalling.
//
// Optional feature: define MULDIV_FAST_MUL_EN to compute multiplies in a
// single cycle with the '*' operator (IDLE -> DONE). Divide is unaffected.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mdOpE             0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//   mdStartE, flushE  op valid this cycle / squash any in-flight op
//   SrcA, SrcB        rs / rt operands
//   hiOut, loOut      architectural HI / LO
//   mdBusy            registered, high in CALC and DONE
//   mdStall           combinational stall request to the pipeline
//   mdDone            registered one-cycle pulse when HI/LO take a new result
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mdOpE,
  input  logic             mdStartE,
  input  logic             flushE,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut,
  output logic             mdBusy,
  output logic             mdStall,
  output logic             mdDone
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  // Multiply: {p_hi,p_lo} is the product shift register, p_lo starts as the
  // multiplier and b_reg holds the multiplicand.
  // Divide: p_hi is the partial remainder, p_lo shifts the dividend out and
  // the quotient in, b_reg holds the divisor.
  logic [WIDTH-1:0] p_hi, p_lo, b_reg;
  logic             op_div, neg_q, neg_r, div_zero;

  logic             start_ok, long_op, is_mul_op, op_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif

  always_comb begin
    start_ok  = (state == IDLE) && mdStartE && !flushE;
    long_op   = (mdOpE >= OP_MULT) && (mdOpE <= OP_DIVU);
    is_mul_op = (mdOpE == OP_MULT) || (mdOpE == OP_MULTU);
    op_signed = (mdOpE == OP_MULT) || (mdOpE == OP_DIV);
    a_neg     = op_signed && SrcA[WIDTH-1];
    b_neg     = op_signed && SrcB[WIDTH-1];
    a_abs     = a_neg ? -SrcA : SrcA;
    b_abs     = b_neg ? -SrcB : SrcB;

    add_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_reg} : '0);
    // The remainder stays below the divisor, so the difference fits in WIDTH
    // bits whenever the trial value is not smaller than the divisor.
    div_trial = {p_hi, p_lo[WIDTH-1]};
    div_ge    = div_trial >= {1'b0, b_reg};
    div_diff  = div_trial[WIDTH-1:0] - b_reg;

    prod_fix  = neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};
    // A zero divisor makes every trial succeed, so the quotient is all ones
    // and the remainder ends up as |dividend|; the remainder sign fixup then
    // restores the original dividend in HI.
    quo_fix   = div_zero ? '1 : (neg_q ? -p_lo : p_lo);
    rem_fix   = neg_r ? -p_hi : p_hi;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = (2*WIDTH)'(a_abs) * (2*WIDTH)'(b_abs);
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok && long_op) begin
`ifdef MULDIV_FAST_MUL_EN
          state_nxt = is_mul_op ? DONE : CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC: begin
        if (flushE)                   state_nxt = IDLE;
        else if (cnt == CNT_W'(1))    state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mdStall = mdBusy | (start_ok & long_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
      b_reg    <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hiOut    <= '0;
      loOut    <= '0;
      mdBusy   <= 1'b0;
      mdDone   <= 1'b0;
    end else begin
      state  <= state_nxt;
      mdBusy <= (state_nxt != IDLE);
      mdDone <= (state == DONE) && !flushE;
      case (state)
        IDLE: begin
          if (start_ok && long_op) begin
            op_div   <= !is_mul_op;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= !is_mul_op && (SrcB == '0);
            cnt      <= CNT_W'(WIDTH);
            if (is_mul_op) begin
              b_reg <= a_abs;
`ifdef MULDIV_FAST_MUL_EN
              {p_hi, p_lo} <= fast_prod;
`else
              p_hi  <= '0;
              p_lo  <= b_abs;
`endif
            end else begin
              b_reg <= b_abs;
              p_hi  <= '0;
              p_lo  <= a_abs;
            end
          end else if (start_ok && mdOpE == OP_MTHI) begin
            hiOut <= SrcA;
          end else if (start_ok && mdOpE == OP_MTLO) begin
            loOut <= SrcA;
          end
        end
        CALC: begin
          if (!flushE) begin
            cnt <= cnt - CNT_W'(1);
            if (op_div) begin
              p_hi <= div_ge ? div_diff : div_trial[WIDTH-1:0];
              p_lo <= {p_lo[WIDTH-2:0], div_ge};
            end else begin
              p_hi <= add_sum[WIDTH:1];
              p_lo <= {add_sum[0], p_lo[WIDTH-1:1]};
            end
          end
        end
        DONE: begin
          if (!flushE) begin
            if (op_div) begin
              hiOut <= rem_fix;
              loOut <= quo_fix;
            end else begin
              {hiOut, loOut} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Execute-stage multi-cycle multiply/divide unit. It sits beside the ALU and consumes the same forwarded SrcA/SrcB operands. It owns the architectural HI/LO registers and stalls the pipeline while an iterative operation runs. hiOut/loOut feed the MFHI/MFLO path into the execute result mux.

Parameters:
WIDTH, 32, operand and HI/LO width (must be even, >= 8)
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
mdOpE  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP)
mdStartE  in  1  op in mdOpE is valid this cycle
flushE  in  1  squash: abort any in-flight op
SrcA  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
SrcB  in  WIDTH  rt operand (divisor / multiplier)
hiOut  out  WIDTH  HI register
loOut  out  WIDTH  LO register
mdBusy  out  1  registered; high in CALC and DONE
mdStall  out  1  combinational: mdBusy | (state==IDLE & mdStartE & op in 1..4 & !flushE)
mdDone  out  1  registered one-cycle pulse; HI/LO hold the new result in that cycle

Behaviour:
- Reset (rst_n low, async): state IDLE; hiOut = loOut = 0; mdBusy = mdDone = 0; counter and datapath registers = 0. Reset mid-operation abandons the op. HI/LO return to 0.
- FSM states:
  - IDLE: start & op 1..4 & !flushE -> CALC. Latch absolute values (signed ops) or raw values (unsigned ops), sign flags, op, counter = WIDTH.
  - CALC: one radix-2 step per cycle. MULT: shift-add. DIV: restoring subtract-shift. Counter decrements; at 1 -> DONE.
  - DONE: sign fixup, write HI/LO at the end of the cycle -> IDLE. mdDone = 1 in the following cycle.
- Latency (no fast-mul feature): start sampled at edge of cycle 0. CALC occupies cycles 1..WIDTH, DONE is cycle WIDTH+1. New HI/LO, mdBusy = 0 and mdDone = 1 all appear in cycle WIDTH+2 (34 for WIDTH=32).
- Multiply: {HI,LO} = full 2*WIDTH product. Signed result is negated when exactly one operand is negative.
- Divide:
  - LO = quotient, HI = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero (checked at start): LO = all ones, HI = dividend. Still takes the full latency.
  - Signed overflow (most negative / -1): LO = most negative value, HI = 0.
- MTHI/MTLO: accepted only in IDLE with start & !flushE. Writes HI (or LO) = SrcA at that edge, visible next cycle. No busy, no stall, no mdDone.
- mdStartE while busy: ignored. The op is expected to be replayed after the stall releases.
- flushE in CALC or DONE: next state IDLE, HI/LO unchanged, no mdDone. flushE together with a start in IDLE: start is ignored.
- mdStall is asserted in the start cycle, so upstream stages freeze in the same cycle an op is accepted.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MULT/MULTU compute in one cycle using the `*` operator. Path is IDLE -> DONE, so HI/LO and mdDone appear in cycle 2. Divide is unchanged.
- Undefined: multiplies use the iterative path with the WIDTH+2 latency above. This build uses no hardware multiplier.

Test Plan:
- Reset then MULT SrcA=0xFFFFFFFD (-3), SrcB=5 -> cycles 0..33 mdStall=1. Cycle 34: HI=0xFFFFFFFF, LO=0xFFFFFFF1, mdDone=1 for one cycle.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/0 -> LO=0xFFFFFFFF, HI=7. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x1234 in IDLE -> next cycle hiOut=0x1234, mdStall never high.
- MTLO issued while a DIV is busy -> ignored; LO = quotient at completion.
- DIVU 100/3 with flushE pulsed at cycle 10 -> mdBusy=0 in cycle 11, HI/LO keep prior values, no mdDone.
- rst_n low at cycle 5 of a MULT -> outputs all 0 immediately; a fresh MULTU 6x7 afterwards gives LO=42, HI=0.
- With MULDIV_FAST_MUL_EN defined, MULT 6x7 -> LO=42 in cycle 2.
